hs_rx_multi: RTL

Parametrised multi-channel four-phase handshake receiver for the destination (`bclk`) side of CDC links. Each channel synchronises an asynchronous `req` and captures the sender's held data word. It presents the word to local logic with `bvalid`/`bload` and returns `ack` to the source domain. It is the generalised receive endpoint for all handshake CDC paths, replacing single-channel, data-less receive FSMs.

---
 rtl/hs_rx_pkg.sv | 21 ++
 rtl/hs_rx_chan.sv | 98 +++++++++
 rtl/hs_rx_multi.sv | 40 ++++
 3 files changed

// File: rtl/hs_rx_pkg.sv
// Shared definitions for the multi-channel handshake receiver: FSM state
// encoding and the legal range of the req synchroniser depth.
package hs_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int unsigned SYNC_MIN = 2;
    localparam int unsigned SYNC_MAX = 4;

    // Clamp a requested synchroniser depth into the supported range.
    function automatic int unsigned sync_depth(input int unsigned n);
        if (n < SYNC_MIN) return SYNC_MIN;
        if (n > SYNC_MAX) return SYNC_MAX;
        return n;
    endfunction

endpackage

// File: rtl/hs_rx_chan.sv
// One four-phase handshake receive channel: req synchroniser, IDLE/VALID/ACK
// FSM, data capture register and, with HS_RX_TIMEOUT_EN, an ACK-phase timeout.
module hs_rx_chan
    import hs_rx_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TO_W        = 8
) (
    input  logic          bclk,
    input  logic          brst,
    input  logic          req,
    input  logic [DW-1:0] adata,
    output logic          ack,
    output logic [DW-1:0] bdata,
    output logic          bvalid,
    input  logic          bload,
    output logic          berr,
    input  logic          berr_clr
);

    localparam int unsigned SN = sync_depth(SYNC_STAGES);

    logic [SN-1:0] sync_q;
    logic          req_s;
    state_t        state;
    state_t        state_nxt;
    logic          capture_c;

    // Metastability chain; only req_s is seen by the FSM.
    always_ff @(posedge bclk or posedge brst) begin
        if (brst) sync_q <= '0;
        else      sync_q <= {sync_q[SN-2:0], req};
    end

    assign req_s = sync_q[SN-1];

    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_nxt = VALID;
                    capture_c = 1'b1;
                end
            end
            VALID: if (bload)  state_nxt = ACK;
            ACK:   if (!req_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bvalid/ack come straight from flops so the source domain sees no glitches.
    always_ff @(posedge bclk or posedge brst) begin
        if (brst) begin
            state  <= IDLE;
            bvalid <= 1'b0;
            ack    <= 1'b0;
            bdata  <= '0;
        end else begin
            state  <= state_nxt;
            bvalid <= (state_nxt == VALID);
            ack    <= (state_nxt == ACK);
            if (capture_c) bdata <= adata;
        end
    end

`ifdef HS_RX_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [TO_W-1:0] to_cnt;
    logic            in_ack_c;
    logic            berr_set_c;

    // Counting only while the FSM stays in ACK, i.e. req_s is still high.
    assign in_ack_c   = (state == ACK) && (state_nxt == ACK);
    assign berr_set_c = in_ack_c && (to_cnt == TO_LAST);

    always_ff @(posedge bclk or posedge brst) begin
        if (brst) begin
            to_cnt <= '0;
            berr   <= 1'b0;
        end else begin
            if (!in_ack_c)        to_cnt <= '0;
            else if (to_cnt != '1) to_cnt <= to_cnt + TO_W'(1);
            if (berr_set_c)       berr <= 1'b1;
            else if (berr_clr)    berr <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign berr       = 1'b0;
    assign unused_cfg = ^{berr_clr, 1'(TO_W)};
`endif

endmodule

// File: rtl/hs_rx_multi.sv
// CH-channel handshake receive endpoint; each channel is an independent
// hs_rx_chan. Optional ACK timeout is enabled by defining HS_RX_TIMEOUT_EN.
module hs_rx_multi #(
    parameter int unsigned CH          = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TO_W        = 8
) (
    input  logic             bclk,
    input  logic             brst,
    input  logic [CH-1:0]    req,
    input  logic [CH*DW-1:0] adata,
    output logic [CH-1:0]    ack,
    output logic [CH*DW-1:0] bdata,
    output logic [CH-1:0]    bvalid,
    input  logic [CH-1:0]    bload,
    output logic [CH-1:0]    berr,
    input  logic [CH-1:0]    berr_clr
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        hs_rx_chan #(
            .DW          (DW),
            .SYNC_STAGES (SYNC_STAGES),
            .TO_W        (TO_W)
        ) u_chan (
            .bclk     (bclk),
            .brst     (brst),
            .req      (req[i]),
            .adata    (adata[i*DW +: DW]),
            .ack      (ack[i]),
            .bdata    (bdata[i*DW +: DW]),
            .bvalid   (bvalid[i]),
            .bload    (bload[i]),
            .berr     (berr[i]),
            .berr_clr (berr_clr[i])
        );
    end

endmodule
